// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, req/ack instruction-memory port, IF/ID register.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_f,
   input  logic        stall_d,
   input  logic        pc_src_d,
   input  logic [31:0] pc_branch_d,
   input  logic        jump_d,
   input  logic [31:0] pc_jump_d,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr_d,
   output logic [31:0] pc_plus4_d,
   output logic        valid_d,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_bubbles
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_HOLD = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t      state_r, state_nxt_s;
   logic [31:0] pc_f_r, pc_f_nxt_s;
   logic [31:0] req_addr_r, req_addr_nxt_s;
   logic [31:0] buf_instr_r, buf_pc4_r;
   logic        buf_ld_s;
   logic        ld_ifid_s;
   logic [31:0] instr_nxt_s, pc4_nxt_s;
   logic        valid_nxt_s;
   logic        hold_s, redirect_s;
   logic [31:0] target_s, seq_pc4_s;

   assign hold_s     = stall_f | stall_d;
   assign redirect_s = (pc_src_d | jump_d) & ~hold_s;
   assign target_s   = jump_d ? pc_jump_d : pc_branch_d;
   assign seq_pc4_s  = req_addr_r + 32'd4;

   assign imem_req  = (state_r != S_HOLD);
   assign imem_addr = req_addr_r;

   // Next-state, PC/request-address and IF/ID load selection.
   always_comb begin
      state_nxt_s    = state_r;
      pc_f_nxt_s     = pc_f_r;
      req_addr_nxt_s = req_addr_r;
      buf_ld_s       = 1'b0;
      ld_ifid_s      = 1'b0;
      instr_nxt_s    = 32'd0;
      pc4_nxt_s      = 32'd0;
      valid_nxt_s    = 1'b0;
      case (state_r)
         S_REQ: begin
            if (redirect_s) begin
               ld_ifid_s  = 1'b1;
               pc_f_nxt_s = target_s;
               if (imem_ack) begin
                  req_addr_nxt_s = target_s;
               end else begin
                  // request still in flight: its word must be dropped on arrival
                  state_nxt_s = S_DROP;
               end
            end else if (imem_ack) begin
               if (!hold_s) begin
                  ld_ifid_s      = 1'b1;
                  instr_nxt_s    = imem_rdata;
                  pc4_nxt_s      = seq_pc4_s;
                  valid_nxt_s    = 1'b1;
                  pc_f_nxt_s     = seq_pc4_s;
                  req_addr_nxt_s = seq_pc4_s;
               end else begin
                  buf_ld_s    = 1'b1;
                  state_nxt_s = S_HOLD;
               end
            end else if (!hold_s) begin
               ld_ifid_s = 1'b1;
            end else begin
               ld_ifid_s = 1'b0;
            end
         end
         S_HOLD: begin
            if (redirect_s) begin
               ld_ifid_s      = 1'b1;
               pc_f_nxt_s     = target_s;
               req_addr_nxt_s = target_s;
               state_nxt_s    = S_REQ;
            end else if (!hold_s) begin
               ld_ifid_s      = 1'b1;
               instr_nxt_s    = buf_instr_r;
               pc4_nxt_s      = buf_pc4_r;
               valid_nxt_s    = 1'b1;
               pc_f_nxt_s     = buf_pc4_r;
               req_addr_nxt_s = buf_pc4_r;
               state_nxt_s    = S_REQ;
            end else begin
               ld_ifid_s = 1'b0;
            end
         end
         S_DROP: begin
            if (redirect_s) begin
               pc_f_nxt_s = target_s;
            end else begin
               pc_f_nxt_s = pc_f_r;
            end
            ld_ifid_s = ~hold_s;
            if (imem_ack) begin
               req_addr_nxt_s = pc_f_nxt_s;
               state_nxt_s    = S_REQ;
            end else begin
               state_nxt_s = S_DROP;
            end
         end
         default: begin
            state_nxt_s    = S_REQ;
            pc_f_nxt_s     = RESET_PC;
            req_addr_nxt_s = RESET_PC;
         end
      endcase
   end

   // State, PC, request address, skid buffer and IF/ID registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= S_REQ;
         pc_f_r      <= RESET_PC;
         req_addr_r  <= RESET_PC;
         buf_instr_r <= 32'd0;
         buf_pc4_r   <= 32'd0;
         instr_d     <= 32'd0;
         pc_plus4_d  <= 32'd0;
         valid_d     <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         pc_f_r     <= pc_f_nxt_s;
         req_addr_r <= req_addr_nxt_s;
         if (buf_ld_s) begin
            buf_instr_r <= imem_rdata;
            buf_pc4_r   <= seq_pc4_s;
         end
         if (ld_ifid_s) begin
            instr_d    <= instr_nxt_s;
            pc_plus4_d <= pc4_nxt_s;
            valid_d    <= valid_nxt_s;
         end
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] fetched_r, bubbles_r;

   // Delivered-instruction and bubble counters; every IF/ID load is a non-hold cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetched_r <= 32'd0;
         bubbles_r <= 32'd0;
      end else if (ld_ifid_s) begin
         if (valid_nxt_s) begin
            fetched_r <= fetched_r + 32'd1;
         end else begin
            bubbles_r <= bubbles_r + 32'd1;
         end
      end
   end

   assign perf_fetched = fetched_r;
   assign perf_bubbles = bubbles_r;
`else
   assign perf_fetched = 32'd0;
   assign perf_bubbles = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage (address-as-data memory stimulus).
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_f, stall_d, pc_src_d, jump_d;
   logic [31:0] pc_branch_d, pc_jump_d;
   logic        imem_req, imem_ack;
   logic [31:0] imem_addr, imem_rdata;
   logic [31:0] instr_d, pc_plus4_d;
   logic        valid_d;
   logic [31:0] perf_fetched, perf_bubbles;

   int total = 0;
   int bad   = 0;
   int exp_fetched = 0;
   int exp_bubbles = 0;

   typedef struct {
      logic        sf, sd, br;
      logic [31:0] bt;
      logic        jp;
      logic [31:0] jt;
      logic        ack;
      logic [31:0] rd;
      logic        e_req;
      logic [31:0] e_addr, e_instr, e_pc4;
      logic        e_valid;
   } vec_t;

   vec_t vecs[$];

   fetch_stage dut (
      .clk(clk), .rst(rst),
      .stall_f(stall_f), .stall_d(stall_d),
      .pc_src_d(pc_src_d), .pc_branch_d(pc_branch_d),
      .jump_d(jump_d), .pc_jump_d(pc_jump_d),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr_d(instr_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d),
      .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic sf, input logic sd, input logic br, input logic [31:0] bt,
                      input logic jp, input logic [31:0] jt, input logic ack, input logic [31:0] rd,
                      input logic e_req, input logic [31:0] e_addr, input logic [31:0] e_instr,
                      input logic [31:0] e_pc4, input logic e_valid);
      vec_t v;
      v.sf = sf; v.sd = sd; v.br = br; v.bt = bt; v.jp = jp; v.jt = jt;
      v.ack = ack; v.rd = rd; v.e_req = e_req; v.e_addr = e_addr;
      v.e_instr = e_instr; v.e_pc4 = e_pc4; v.e_valid = e_valid;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic sf, input logic sd, input logic br, input logic [31:0] bt,
                        input logic jp, input logic [31:0] jt, input logic ack, input logic [31:0] rd);
      stall_f = sf; stall_d = sd; pc_src_d = br; pc_branch_d = bt;
      jump_d = jp; pc_jump_d = jt; imem_ack = ack; imem_rdata = rd;
   endtask

   task automatic chk_perf(input string tag);
`ifdef FETCH_PERF_EN
      chk({tag, "_perf_fetched"}, perf_fetched, exp_fetched);
      chk({tag, "_perf_bubbles"}, perf_bubbles, exp_bubbles);
`else
      chk({tag, "_perf_fetched"}, perf_fetched, 32'd0);
      chk({tag, "_perf_bubbles"}, perf_bubbles, 32'd0);
`endif
   endtask

   initial begin
      //  sf   sd   br   btgt           jp   jtgt           ack  rdata          | req  addr           instr          pc4            valid
      add(1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0,         1'b1,32'h0,          1'b1,32'h0,          32'h0,         32'h4,         1'b1);
      add(1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0,         1'b1,32'h4,          1'b1,32'h4,          32'h4,         32'h8,         1'b1);
      add(1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0,         1'b1,32'h8,          1'b1,32'h8,          32'h8,         32'hC,         1'b1);
      add(1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0,         1'b1,32'hC,          1'b1,32'hC,          32'hC,         32'h10,        1'b1);
      // stall while word @0x10 returns, hold for four cycles, then release
      add(1'b1,1'b1,1'b0,32'h0,         1'b0,32'h0,         1'b1,32'h10,         1'b1,32'h10,         32'hC,         32'h10,        1'b1);
      add(1'b1,1'b1,1'b0,32'h0,         1'b0,32'h0,         1'b0,32'h0,          1'b0,32'h10,         32'hC,         32'h10,        1'b1);
      add(1'b1,1'b1,1'b0,32'h0,         1'b0,32'h0,         1'b0,32'h0,          1'b0,32'h10,         32'hC,         32'h10,        1'b1);
      add(1'b1,1'b1,1'b0,32'h0,         1'b0,32'h0,         1'b0,32'h0,          1'b0,32'h10,         32'hC,         32'h10,        1'b1);
      add(1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0,         1'b0,32'h0,          1'b0,32'h10,         32'h10,        32'h14,        1'b1);
      // 3-cycle memory latency
      add(1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0,         1'b0,32'h0,          1'b1,32'h14,         32'h0,         32'h0,         1'b0);
      add(1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0,         1'b0,32'h0,          1'b1,32'h14,         32'h0,         32'h0,         1'b0);
      add(1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0,         1'b1,32'h14,         1'b1,32'h14,         32'h14,        32'h18,        1'b1);
      add(1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0,         1'b0,32'h0,          1'b1,32'h18,         32'h0,         32'h0,         1'b0);
      add(1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0,         1'b0,32'h0,          1'b1,32'h18,         32'h0,         32'h0,         1'b0);
      add(1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0,         1'b1,32'h18,         1'b1,32'h18,         32'h18,        32'h1C,        1'b1);
      // branch while @0x1C outstanding: dropped, then fetch 0x200
      add(1'b0,1'b0,1'b1,32'h200,       1'b0,32'h0,         1'b0,32'h0,          1'b1,32'h1C,         32'h0,         32'h0,         1'b0);
      add(1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0,         1'b0,32'h0,          1'b1,32'h1C,         32'h0,         32'h0,         1'b0);
      add(1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0,         1'b1,32'h1C,         1'b1,32'h1C,         32'h0,         32'h0,         1'b0);
      add(1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0,         1'b1,32'h200,        1'b1,32'h200,        32'h200,       32'h204,       1'b1);
      // branch and jump together with ack: jump wins
      add(1'b0,1'b0,1'b1,32'h300,       1'b1,32'h400,       1'b1,32'h204,        1'b1,32'h204,        32'h0,         32'h0,         1'b0);
      add(1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0,         1'b1,32'h400,        1'b1,32'h400,        32'h400,       32'h404,       1'b1);
      // redirects under hold are ignored
      add(1'b1,1'b0,1'b1,32'h500,       1'b0,32'h0,         1'b0,32'h0,          1'b1,32'h404,        32'h400,       32'h404,       1'b1);
      add(1'b0,1'b1,1'b0,32'h0,         1'b1,32'h600,       1'b1,32'h404,        1'b1,32'h404,        32'h400,       32'h404,       1'b1);
      add(1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0,         1'b0,32'h0,          1'b0,32'h404,        32'h404,       32'h408,       1'b1);
      // redirect out of S_HOLD discards the buffered word
      add(1'b1,1'b1,1'b0,32'h0,         1'b0,32'h0,         1'b1,32'h408,        1'b1,32'h408,        32'h404,       32'h408,       1'b1);
      add(1'b0,1'b0,1'b0,32'h0,         1'b1,32'h700,       1'b0,32'h0,          1'b0,32'h408,        32'h0,         32'h0,         1'b0);
      add(1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0,         1'b1,32'h700,        1'b1,32'h700,        32'h700,       32'h704,       1'b1);
      // second redirect inside S_DROP replaces the target
      add(1'b0,1'b0,1'b1,32'h800,       1'b0,32'h0,         1'b0,32'h0,          1'b1,32'h704,        32'h0,         32'h0,         1'b0);
      add(1'b0,1'b0,1'b0,32'h0,         1'b1,32'h900,       1'b0,32'h0,          1'b1,32'h704,        32'h0,         32'h0,         1'b0);
      add(1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0,         1'b1,32'h704,        1'b1,32'h704,        32'h0,         32'h0,         1'b0);
      add(1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0,         1'b1,32'h900,        1'b1,32'h900,        32'h900,       32'h904,       1'b1);
      // address wrap at the top of memory
      add(1'b0,1'b0,1'b0,32'h0,         1'b1,32'hFFFF_FFFC, 1'b1,32'h904,        1'b1,32'h904,        32'h0,         32'h0,         1'b0);
      add(1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0,         1'b1,32'hFFFF_FFFC,  1'b1,32'hFFFF_FFFC,  32'hFFFF_FFFC, 32'h0,         1'b1);
      add(1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0,         1'b1,32'h0,          1'b1,32'h0,          32'h0,         32'h4,         1'b1);

      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", {31'd0, imem_req}, 32'd1);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_instr", instr_d, 32'h0);
      chk("rst_pc4", pc_plus4_d, 32'h0);
      chk("rst_valid", {31'd0, valid_d}, 32'd0);
      chk_perf("rst");
      rst = 1'b0;

      foreach (vecs[i]) begin
         drive(vecs[i].sf, vecs[i].sd, vecs[i].br, vecs[i].bt,
               vecs[i].jp, vecs[i].jt, vecs[i].ack, vecs[i].rd);
         #1;
         chk($sformatf("v%0d_req", i), {31'd0, imem_req}, {31'd0, vecs[i].e_req});
         chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
         if (!(vecs[i].sf | vecs[i].sd)) begin
            if (vecs[i].e_valid) exp_fetched++;
            else exp_bubbles++;
         end
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_instr", i), instr_d, vecs[i].e_instr);
         chk($sformatf("v%0d_valid", i), {31'd0, valid_d}, {31'd0, vecs[i].e_valid});
         if (vecs[i].e_valid) chk($sformatf("v%0d_pc4", i), pc_plus4_d, vecs[i].e_pc4);
         chk_perf($sformatf("v%0d", i));
      end

      // reset asserted while parked in S_HOLD
      drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h4);
      @(posedge clk);
      #1;
      chk("hold_req", {31'd0, imem_req}, 32'd0);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_req", {31'd0, imem_req}, 32'd1);
      chk("arst_addr", imem_addr, 32'h0);
      chk("arst_instr", instr_d, 32'h0);
      chk("arst_pc4", pc_plus4_d, 32'h0);
      chk("arst_valid", {31'd0, valid_d}, 32'd0);
      exp_fetched = 0;
      exp_bubbles = 0;
      chk_perf("arst");
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0);
      #1;
      chk("post_addr", imem_addr, 32'h0);
      @(posedge clk);
      #1;
      chk("post_instr", instr_d, 32'h0);
      chk("post_pc4", pc_plus4_d, 32'h4);
      chk("post_valid", {31'd0, valid_d}, 32'd1);
      chk("post_next_addr", imem_addr, 32'h4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
